// File: rtl/smc_qbus_arbiter.sv
// -----------------------------------------------------------------------------
// smc_qbus_arbiter
//   Two-requester arbiter and sequencer for the stepper-motor-controller Q-bus
//   register file. One request is granted at a time, either round-robin or with
//   fixed priority for requester 0. Each mapped access drives exactly one QSEL
//   cycle. Reads capture the registered QDATAOUT. Unmapped addresses are
//   answered with ERR and never reach the bus.
//
// Handshake: a request transfers on a cycle where Rn_VALID && Rn_READY.
//   The requester holds VALID with stable fields until READY. READY is
//   combinational, high only in IDLE and only for the granted requester.
//   The response is a single-cycle Rn_RVALID pulse with no backpressure.
//
// Ports
//   QCLK, QRESET            clock, synchronous active-high reset
//   R0_* / R1_*             request channel (VALID/READY/WRITE/ADDR/WDATA) and
//                           response (RVALID/RDATA/ERR) per requester
//   QSEL/QWRITE/QADDR/QDATAIN  register-file access, all zero outside ISSUE
//   QDATAOUT                register-file read data, valid the cycle after QSEL
// -----------------------------------------------------------------------------
module smc_qbus_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        QCLK,
    input  logic        QRESET,
    input  logic        R0_VALID,
    output logic        R0_READY,
    input  logic        R0_WRITE,
    input  logic [6:0]  R0_ADDR,
    input  logic [15:0] R0_WDATA,
    output logic        R0_RVALID,
    output logic [15:0] R0_RDATA,
    output logic        R0_ERR,
    input  logic        R1_VALID,
    output logic        R1_READY,
    input  logic        R1_WRITE,
    input  logic [6:0]  R1_ADDR,
    input  logic [15:0] R1_WDATA,
    output logic        R1_RVALID,
    output logic [15:0] R1_RDATA,
    output logic        R1_ERR,
    output logic        QSEL,
    output logic        QWRITE,
    output logic [6:0]  QADDR,
    output logic [15:0] QDATAIN,
    input  logic [15:0] QDATAOUT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state;
    logic        lat_id;     // requester owning the access in flight
    logic        lat_write;
    logic        rr_last;    // id granted most recently; the other one wins a tie
    logic        gnt0;
    logic        gnt1;
    logic        sel_write;
    logic [6:0]  sel_addr;
    logic [15:0] sel_wdata;

    function automatic logic addr_mapped(input logic [6:0] a);
        logic m;
        m = 1'b0;
        if (a == 7'h00 || a == 7'h02 || a == 7'h03)
            m = 1'b1;
        else if (a >= 7'h10 && a <= 7'h1B)
            m = 1'b1;
        else if (a >= 7'h20 && a <= 7'h36 && !a[0])
            m = 1'b1;
        return m;
    endfunction

    // Grant is gated by reset so a VALID during reset never handshakes.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == S_IDLE && !QRESET) begin
            if (R0_VALID && R1_VALID) begin
                if (FIXED_PRIO || rr_last)
                    gnt0 = 1'b1;
                else
                    gnt1 = 1'b1;
            end else if (R0_VALID) begin
                gnt0 = 1'b1;
            end else if (R1_VALID) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign R0_READY  = gnt0;
    assign R1_READY  = gnt1;
    assign sel_write = gnt1 ? R1_WRITE : R0_WRITE;
    assign sel_addr  = gnt1 ? R1_ADDR  : R0_ADDR;
    assign sel_wdata = gnt1 ? R1_WDATA : R0_WDATA;

    // Outputs are registered: each is set on the edge entering the state
    // in which it must be visible, and cleared by default otherwise.
    always_ff @(posedge QCLK) begin
        if (QRESET) begin
            state     <= S_IDLE;
            lat_id    <= 1'b0;
            lat_write <= 1'b0;
            rr_last   <= 1'b1;
            QSEL      <= 1'b0;
            QWRITE    <= 1'b0;
            QADDR     <= '0;
            QDATAIN   <= '0;
            R0_RVALID <= 1'b0;
            R0_RDATA  <= '0;
            R0_ERR    <= 1'b0;
            R1_RVALID <= 1'b0;
            R1_RDATA  <= '0;
            R1_ERR    <= 1'b0;
        end else begin
            QSEL      <= 1'b0;
            QWRITE    <= 1'b0;
            QADDR     <= '0;
            QDATAIN   <= '0;
            R0_RVALID <= 1'b0;
            R0_RDATA  <= '0;
            R0_ERR    <= 1'b0;
            R1_RVALID <= 1'b0;
            R1_RDATA  <= '0;
            R1_ERR    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gnt0 || gnt1) begin
                        lat_id    <= gnt1;
                        lat_write <= sel_write;
                        rr_last   <= gnt1;
                        if (addr_mapped(sel_addr)) begin
                            state   <= S_ISSUE;
                            QSEL    <= 1'b1;
                            QWRITE  <= sel_write;
                            QADDR   <= sel_addr;
                            QDATAIN <= sel_wdata;
                        end else begin
                            // Unmapped: answer straight away, bus untouched.
                            state <= S_RESP;
                            if (gnt1) begin
                                R1_RVALID <= 1'b1;
                                R1_ERR    <= 1'b1;
                            end else begin
                                R0_RVALID <= 1'b1;
                                R0_ERR    <= 1'b1;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (lat_write) begin
                        state <= S_RESP;
                        if (lat_id) R1_RVALID <= 1'b1;
                        else        R0_RVALID <= 1'b1;
                    end else begin
                        state <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    // QDATAOUT is valid now, one cycle after the read QSEL.
                    state <= S_RESP;
                    if (lat_id) begin
                        R1_RVALID <= 1'b1;
                        R1_RDATA  <= QDATAOUT;
                    end else begin
                        R0_RVALID <= 1'b1;
                        R0_RDATA  <= QDATAOUT;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smc_qbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_smc_qbus_arbiter
//   Directed bench for smc_qbus_arbiter. A round-robin instance carries the
//   main vector table; a fixed-priority instance shares its inputs and is
//   checked in the tie sequence. A small register-file model answers reads.
// -----------------------------------------------------------------------------
module tb_smc_qbus_arbiter;

    typedef struct packed {
        logic        v0;
        logic        w0;
        logic [6:0]  a0;
        logic [15:0] d0;
        logic        v1;
        logic        w1;
        logic [6:0]  a1;
        logic [15:0] d1;
    } in_t;

    typedef struct packed {
        logic        rdy0;
        logic        rdy1;
        logic        qsel;
        logic        qwrite;
        logic [6:0]  qaddr;
        logic [15:0] qdin;
        logic        rv0;
        logic [15:0] rd0;
        logic        e0;
        logic        rv1;
        logic [15:0] rd1;
        logic        e1;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    localparam in_t  IDLE_IN = '0;
    localparam exp_t X_NONE  = '0;

    // ---------------- clock / reset ----------------
    logic clk;
    logic qreset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        r0_valid, r0_ready, r0_write, r0_rvalid, r0_err;
    logic [6:0]  r0_addr;
    logic [15:0] r0_wdata, r0_rdata;
    logic        r1_valid, r1_ready, r1_write, r1_rvalid, r1_err;
    logic [6:0]  r1_addr;
    logic [15:0] r1_wdata, r1_rdata;
    logic        qsel, qwrite;
    logic [6:0]  qaddr;
    logic [15:0] qdatain, qdataout;

    logic        f_r0_ready, f_r0_rvalid, f_r0_err;
    logic [15:0] f_r0_rdata;
    logic        f_r1_ready, f_r1_rvalid, f_r1_err;
    logic [15:0] f_r1_rdata;
    logic        f_qsel, f_qwrite;
    logic [6:0]  f_qaddr;
    logic [15:0] f_qdatain;
    logic [15:0] f_qdataout;

    assign f_qdataout = 16'h0000;

    smc_qbus_arbiter #(.FIXED_PRIO(1'b0)) u_dut (
        .QCLK(clk), .QRESET(qreset),
        .R0_VALID(r0_valid), .R0_READY(r0_ready), .R0_WRITE(r0_write),
        .R0_ADDR(r0_addr), .R0_WDATA(r0_wdata), .R0_RVALID(r0_rvalid),
        .R0_RDATA(r0_rdata), .R0_ERR(r0_err),
        .R1_VALID(r1_valid), .R1_READY(r1_ready), .R1_WRITE(r1_write),
        .R1_ADDR(r1_addr), .R1_WDATA(r1_wdata), .R1_RVALID(r1_rvalid),
        .R1_RDATA(r1_rdata), .R1_ERR(r1_err),
        .QSEL(qsel), .QWRITE(qwrite), .QADDR(qaddr), .QDATAIN(qdatain),
        .QDATAOUT(qdataout)
    );

    smc_qbus_arbiter #(.FIXED_PRIO(1'b1)) u_dut_fp (
        .QCLK(clk), .QRESET(qreset),
        .R0_VALID(r0_valid), .R0_READY(f_r0_ready), .R0_WRITE(r0_write),
        .R0_ADDR(r0_addr), .R0_WDATA(r0_wdata), .R0_RVALID(f_r0_rvalid),
        .R0_RDATA(f_r0_rdata), .R0_ERR(f_r0_err),
        .R1_VALID(r1_valid), .R1_READY(f_r1_ready), .R1_WRITE(r1_write),
        .R1_ADDR(r1_addr), .R1_WDATA(r1_wdata), .R1_RVALID(f_r1_rvalid),
        .R1_RDATA(f_r1_rdata), .R1_ERR(f_r1_err),
        .QSEL(f_qsel), .QWRITE(f_qwrite), .QADDR(f_qaddr), .QDATAIN(f_qdatain),
        .QDATAOUT(f_qdataout)
    );

    // ---------------- register-file model ----------------
    logic [15:0] mem [128];
    always @(posedge clk) begin
        if (qreset) begin
            for (int k = 0; k < 128; k++) mem[k] <= '0;
            qdataout <= '0;
        end else begin
            if (qsel && qwrite)  mem[qaddr] <= qdatain;
            if (qsel && !qwrite) qdataout   <= mem[qaddr];
        end
    end

    // ---------------- scoreboard ----------------
    int          n_vec;
    int          n_bad;
    logic [0:0]  exp_q[$];
    vec_t        tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t sample();
        exp_t s;
        s.rdy0   = r0_ready;
        s.rdy1   = r1_ready;
        s.qsel   = qsel;
        s.qwrite = qwrite;
        s.qaddr  = qaddr;
        s.qdin   = qdatain;
        s.rv0    = r0_rvalid;
        s.rd0    = r0_rdata;
        s.e0     = r0_err;
        s.rv1    = r1_rvalid;
        s.rd1    = r1_rdata;
        s.e1     = r1_err;
        return s;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic in_t q0(input logic w, input logic [6:0] a, input logic [15:0] d);
        in_t r;
        r = '0;
        r.v0 = 1'b1; r.w0 = w; r.a0 = a; r.d0 = d;
        return r;
    endfunction

    function automatic in_t q1(input logic w, input logic [6:0] a, input logic [15:0] d);
        in_t r;
        r = '0;
        r.v1 = 1'b1; r.w1 = w; r.a1 = a; r.d1 = d;
        return r;
    endfunction

    function automatic exp_t x_rdy0();
        exp_t r;
        r = '0;
        r.rdy0 = 1'b1;
        return r;
    endfunction

    function automatic exp_t x_rdy1();
        exp_t r;
        r = '0;
        r.rdy1 = 1'b1;
        return r;
    endfunction

    function automatic exp_t x_sel(input logic w, input logic [6:0] a, input logic [15:0] d);
        exp_t r;
        r = '0;
        r.qsel = 1'b1; r.qwrite = w; r.qaddr = a; r.qdin = d;
        return r;
    endfunction

    function automatic exp_t x_rv0(input logic [15:0] d, input logic e);
        exp_t r;
        r = '0;
        r.rv0 = 1'b1; r.rd0 = d; r.e0 = e;
        return r;
    endfunction

    function automatic exp_t x_rv1(input logic [15:0] d, input logic e);
        exp_t r;
        r = '0;
        r.rv1 = 1'b1; r.rd1 = d; r.e1 = e;
        return r;
    endfunction

    task automatic drive(input in_t i);
        r0_valid = i.v0; r0_write = i.w0; r0_addr = i.a0; r0_wdata = i.d0;
        r1_valid = i.v1; r1_write = i.w1; r1_addr = i.a1; r1_wdata = i.d1;
    endtask

    task automatic row(input in_t i, input exp_t e);
        tbl.push_back(vec_t'({i, e}));
    endtask

    // One cycle: inputs change just after the edge, outputs checked mid-cycle.
    task automatic step(input string nm, input in_t i, input exp_t e);
        @(posedge clk);
        #1;
        drive(i);
        @(negedge clk);
        chk(nm, sample(), e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        qreset = 1'b1;
        drive(IDLE_IN);
        @(posedge clk);
        #1;
        qreset = 1'b0;
    endtask

    // ---------------- test ----------------
    int grants, f_grants, qsels;
    logic [0:0] g_exp;

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        qreset = 1'b1;
        drive(q0(1'b1, 7'h22, 16'h1111) | q1(1'b0, 7'h02, 16'h0000));

        // Reset with both VALIDs high: nothing may be granted or driven.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", sample(), X_NONE);
        @(posedge clk);
        #1;
        qreset = 1'b0;
        drive(IDLE_IN);

        // Cycle-by-cycle vector table.
        row(q0(1'b1, 7'h22, 16'hBEEF), x_rdy0());
        row(IDLE_IN, x_sel(1'b1, 7'h22, 16'hBEEF));
        row(IDLE_IN, x_rv0(16'h0000, 1'b0));
        row(q1(1'b0, 7'h22, 16'h0000), x_rdy1());
        row(IDLE_IN, x_sel(1'b0, 7'h22, 16'h0000));
        row(IDLE_IN, X_NONE);
        row(IDLE_IN, x_rv1(16'hBEEF, 1'b0));
        row(q1(1'b0, 7'h05, 16'h0000), x_rdy1());
        row(q0(1'b1, 7'h1B, 16'h00A5), x_rv1(16'h0000, 1'b1));
        row(q0(1'b1, 7'h1B, 16'h00A5), x_rdy0());
        row(IDLE_IN, x_sel(1'b1, 7'h1B, 16'h00A5));
        row(IDLE_IN, x_rv0(16'h0000, 1'b0));
        row(q0(1'b0, 7'h1B, 16'h0000) | q1(1'b1, 7'h02, 16'h1234), x_rdy1());
        row(q0(1'b0, 7'h1B, 16'h0000), x_sel(1'b1, 7'h02, 16'h1234));
        row(q0(1'b0, 7'h1B, 16'h0000), x_rv1(16'h0000, 1'b0));
        row(q0(1'b0, 7'h1B, 16'h0000), x_rdy0());
        row(IDLE_IN, x_sel(1'b0, 7'h1B, 16'h0000));
        row(IDLE_IN, X_NONE);
        row(IDLE_IN, x_rv0(16'h00A5, 1'b0));
        row(q0(1'b0, 7'h1C, 16'h0000), x_rdy0());
        row(IDLE_IN, x_rv0(16'h0000, 1'b1));
        row(q1(1'b1, 7'h21, 16'hFFFF), x_rdy1());
        row(IDLE_IN, x_rv1(16'h0000, 1'b1));
        row(q0(1'b1, 7'h36, 16'h5A5A), x_rdy0());
        row(IDLE_IN, x_sel(1'b1, 7'h36, 16'h5A5A));
        row(IDLE_IN, x_rv0(16'h0000, 1'b0));
        row(q1(1'b0, 7'h37, 16'h0000), x_rdy1());
        row(IDLE_IN, x_rv1(16'h0000, 1'b1));
        row(q1(1'b0, 7'h36, 16'h0000), x_rdy1());
        row(IDLE_IN, x_sel(1'b0, 7'h36, 16'h0000));
        row(IDLE_IN, X_NONE);
        row(IDLE_IN, x_rv1(16'h5A5A, 1'b0));
        row(IDLE_IN, X_NONE);

        for (int k = 0; k < tbl.size(); k++)
            step($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);

        // Both requesters hold VALID: round-robin alternates, fixed picks R0.
        do_reset();
        @(posedge clk);
        #1;
        drive(q0(1'b1, 7'h10, 16'h0001) | q1(1'b1, 7'h11, 16'h0002));
        for (int k = 0; k < 10; k++) exp_q.push_back(k[0]);
        grants   = 0;
        f_grants = 0;
        qsels    = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (qsel) qsels++;
            if (r0_ready || r1_ready) begin
                grants++;
                if (exp_q.size() == 0) begin
                    chk("rr_extra_grant", 64'(grants), 64'd10);
                end else begin
                    g_exp = exp_q.pop_front();
                    chk("rr_grant", 64'({r0_ready, r1_ready}), g_exp[0] ? 64'd1 : 64'd2);
                end
            end
            if (f_r0_ready || f_r1_ready) begin
                f_grants++;
                chk("fixed_grant", 64'({f_r0_ready, f_r1_ready}), 64'd2);
            end
        end
        drive(IDLE_IN);
        repeat (4) begin
            @(negedge clk);
            if (qsel) qsels++;
        end
        chk("rr_grant_count", 64'(grants), 64'd10);
        chk("fixed_grant_count", 64'(f_grants), 64'd10);
        chk("one_qsel_per_access", 64'(qsels), 64'(grants));

        // Reset while a read is on the bus: response dropped, pointer restored.
        do_reset();
        step("rmid_hs", q0(1'b0, 7'h1B, 16'h0000), x_rdy0());
        @(posedge clk);
        #1;
        drive(IDLE_IN);
        qreset = 1'b1;
        @(negedge clk);
        chk("rmid_issue", sample(), x_sel(1'b0, 7'h1B, 16'h0000));
        @(posedge clk);
        #1;
        qreset = 1'b0;
        @(negedge clk);
        chk("rmid_after", sample(), X_NONE);
        for (int k = 0; k < 3; k++) step("rmid_quiet", IDLE_IN, X_NONE);
        step("rmid_tie", q0(1'b0, 7'h02, 16'h0000) | q1(1'b0, 7'h03, 16'h0000), x_rdy0());
        @(posedge clk);
        #1;
        drive(IDLE_IN);
        repeat (6) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
